// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU
// that sits between the register file read ports and its write-back port.
package alu_seq_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHF = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Opcodes that iterate one bit position per clock.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHF) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step or a
// single-bit shift/rotate. Purely combinational; the caller owns all state.
module alu_seq_step
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] res,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_next,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next
);

    // MUL accumulates into res; the shift ops read their direction from b's MSB.
    always_comb begin
        res_next = res;
        a_next   = a;
        b_next   = b;
        case (op)
            OP_MUL: begin
                if (b[0]) begin
                    res_next = res + a;
                end else begin
                    res_next = res;
                end
                a_next = {a[WIDTH-2:0], 1'b0};
                b_next = {1'b0, b[WIDTH-1:1]};
            end
            OP_SHF: begin
                if (b[WIDTH-1]) begin
                    res_next = {1'b0, res[WIDTH-1:1]};
                end else begin
                    res_next = {res[WIDTH-2:0], 1'b0};
                end
            end
            OP_SRA:  res_next = {res[WIDTH-1], res[WIDTH-1:1]};
            OP_ROR:  res_next = {res[0], res[WIDTH-1:1]};
            default: res_next = res;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add ops, iterative MUL and 1-bit/cycle
// shifts. DONE is the one-cycle write-back strobe for the register file.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             START,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ZERO
);

    localparam int CNT_W = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for the multiply.
    localparam logic [CNT_W:0] CNT_FULL = (CNT_W + 1)'(WIDTH);
    localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [2:0]       op_r, op_s;
    logic [CNT_W:0]   cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [WIDTH-1:0] single_s;
    logic [CNT_W-1:0] k_s;
    logic [WIDTH-1:0] step_res_s, step_a_s, step_b_s;

    assign k_s = DATA2[CNT_W-1:0];

    alu_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_r),
        .res      (result_r),
        .a        (a_r),
        .b        (b_r),
        .res_next (step_res_s),
        .a_next   (step_a_s),
        .b_next   (step_b_s)
    );

    // Result of the opcodes that complete at the accepting edge.
    always_comb begin
        single_s = DATA2;
        case (SELECT)
            OP_FWD:  single_s = DATA2;
            OP_ADD:  single_s = DATA1 + DATA2;
            OP_AND:  single_s = DATA1 & DATA2;
            OP_OR:   single_s = DATA1 | DATA2;
            default: single_s = DATA2;
        endcase
    end

    // FSM next-state, datapath register updates and next BUSY/DONE.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        a_s      = a_r;
        b_s      = b_r;
        op_s     = op_r;
        cnt_s    = cnt_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (START) begin
                    op_s = SELECT;
                    a_s  = DATA1;
                    b_s  = DATA2;
                    if (SELECT == OP_MUL) begin
                        result_s = {WIDTH{1'b0}};
                        cnt_s    = CNT_FULL;
                        state_s  = S_RUN;
                        busy_s   = 1'b1;
                    end else if (is_shift_op(SELECT)) begin
                        result_s = DATA1;
                        if (k_s != {CNT_W{1'b0}}) begin
                            cnt_s   = {1'b0, k_s};
                            state_s = S_RUN;
                            busy_s  = 1'b1;
                        end else begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                        end
                    end else begin
                        result_s = single_s;
                        state_s  = S_DONE;
                        done_s   = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                result_s = step_res_s;
                a_s      = step_a_s;
                b_s      = step_b_s;
                cnt_s    = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_RUN;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including mid-op.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r  <= S_IDLE;
            result_r <= {WIDTH{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            op_r     <= 3'b000;
            cnt_r    <= {(CNT_W + 1){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            a_r      <= a_s;
            b_r      <= b_s;
            op_r     <= op_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign RESULT = result_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ZERO   = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them whenever DONE is presented.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] DATA1, DATA2;
    logic [2:0] SELECT;
    logic       START;
    logic [7:0] RESULT;
    logic       BUSY, DONE, ZERO;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       z;
        int         cyc;
        int         busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .SELECT  (SELECT),
        .START   (START),
        .RESULT  (RESULT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ZERO    (ZERO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    // Called at a negedge; START is held for one edge, then operands are scrambled.
    task automatic issue(input string nm, input logic [2:0] sel, input logic [7:0] d1,
                         input logic [7:0] d2, input bit push, input logic [7:0] er,
                         input logic ez, input int lat, input int bsy);
        exp_t e;
        SELECT = sel;
        DATA1  = d1;
        DATA2  = d2;
        START  = 1'b1;
        if (push) begin
            e.name = nm;
            e.res  = er;
            e.z    = ez;
            e.cyc  = cyc + 1 + lat;
            e.busy = bsy;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        START  = 1'b0;
        DATA1  = ~d1;
        DATA2  = ~d2;
        SELECT = ~sel;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge CLK);
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge CLK);
    endtask

    // Monitor: count BUSY cycles and score every DONE strobe.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET_N) begin
            busy_cnt = 0;
        end else begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got DONE=1 RESULT=%h, expected no pending op", RESULT);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_result"}, RESULT, e.res);
                    check({e.name, "_zero"}, ZERO, e.z);
                    check({e.name, "_latency"}, cyc, e.cyc);
                    check({e.name, "_busy_cycles"}, busy_cnt, e.busy);
                    check({e.name, "_busy_and_done"}, BUSY, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0;
        START   = 1'b0;
        DATA1   = 8'h00;
        DATA2   = 8'h00;
        SELECT  = 3'b000;
        repeat (2) @(negedge CLK);
        check("reset_result", RESULT, 8'h00);
        check("reset_zero", ZERO, 1);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        issue("add_7f_01", 3'b001, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 0, 0);
        drain();
        issue("add_ff_01", 3'b001, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 0, 0);
        drain();
        issue("fwd_3c", 3'b000, 8'h11, 8'h3C, 1'b1, 8'h3C, 1'b0, 0, 0);
        drain();
        issue("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 0, 0);
        drain();
        issue("or_f0_0f", 3'b011, 8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0, 0, 0);
        drain();
        issue("mul_13_11", 3'b100, 8'd13, 8'd11, 1'b1, 8'h8F, 1'b0, 8, 8);
        drain();
        issue("mul_10_10", 3'b100, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 8, 8);
        drain();
        issue("sra_90_3", 3'b110, 8'h90, 8'h03, 1'b1, 8'hF2, 1'b0, 3, 3);
        drain();
        issue("ror_01_1", 3'b111, 8'h01, 8'h01, 1'b1, 8'h80, 1'b0, 1, 1);
        drain();
        issue("shr_f0_2", 3'b101, 8'hF0, 8'h82, 1'b1, 8'h3C, 1'b0, 2, 2);
        drain();
        issue("shl_81_1", 3'b101, 8'h81, 8'h01, 1'b1, 8'h02, 1'b0, 1, 1);
        drain();
        issue("shl_a5_0", 3'b101, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 0, 0);
        drain();

        // START during BUSY is ignored; START in the DONE cycle chains with no bubble.
        issue("mul_3_5", 3'b100, 8'd3, 8'd5, 1'b1, 8'h0F, 1'b0, 8, 8);
        repeat (2) @(negedge CLK);
        issue("add_ignored", 3'b001, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 0, 0);
        for (int i = 0; i < 20 && !DONE; i++) @(negedge CLK);
        check("mul_3_5_done_seen", DONE, 1);
        issue("add_chained", 3'b001, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 0, 0);
        drain();

        // Asynchronous reset between edges in the middle of a multiply.
        issue("mul_killed", 3'b100, 8'h21, 8'h07, 1'b0, 8'h00, 1'b0, 0, 0);
        repeat (2) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("midop_reset_busy", BUSY, 0);
        check("midop_reset_done", DONE, 0);
        check("midop_reset_result", RESULT, 8'h00);
        check("midop_reset_zero", ZERO, 1);
        repeat (2) @(negedge CLK);
        #2 RESET_N = 1'b1;
        @(negedge CLK);
        issue("add_2_3", 3'b001, 8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
